// File: rtl/tr_move_sequencer_pkg.sv
// Shared types and default widths for the TR move sequencer slice.
package tr_pkg;

  localparam int unsigned WIDTH_TR_DEF   = 16;
  localparam int unsigned WIDTH_CNT_DEF  = 32;
  localparam int unsigned SETTLE_CYC_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ACCEL,
    CRUISE,
    DECEL
  } tr_state_t;

endpackage

// File: rtl/tr_move_sequencer_if.sv
// Command/status bundle between a move controller (master) and the sequencer (slave).
interface tr_move_if #(
  parameter int unsigned WIDTH_TR  = 16,
  parameter int unsigned WIDTH_CNT = 32
);

  logic                 start;
  logic                 stop;
  logic                 abort;
  logic                 dir_cmd;
  logic [WIDTH_CNT-1:0] pulse_num;
  logic [WIDTH_TR-1:0]  period_start;
  logic [WIDTH_TR-1:0]  period_target;
  logic [WIDTH_TR-1:0]  period_step;
  logic                 step_tick;

  logic                 drv_en;
  logic                 dir;
  logic [WIDTH_TR-1:0]  period;
  logic                 busy;
  logic                 done;
  logic                 aborted;
  logic [WIDTH_CNT-1:0] pulse_cnt;

  modport master (
    output start, stop, abort, dir_cmd, pulse_num,
           period_start, period_target, period_step, step_tick,
    input  drv_en, dir, period, busy, done, aborted, pulse_cnt
  );

  modport slave (
    input  start, stop, abort, dir_cmd, pulse_num,
           period_start, period_target, period_step, step_tick,
    output drv_en, dir, period, busy, done, aborted, pulse_cnt
  );

endinterface

// File: rtl/tr_move_sequencer_ramp.sv
// Combinational saturating period adjust: period +/- step, clamped to limit.
module tr_ramp_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir_up,
  output logic [WIDTH-1:0] next_period
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Extra MSB catches carry/borrow so wraparound always clamps to limit
  always_comb begin
    sum         = {1'b0, period} + {1'b0, step};
    diff        = {1'b0, period} - {1'b0, step};
    next_period = period;
    if (dir_up) begin
      next_period = (sum > {1'b0, limit}) ? limit : sum[WIDTH-1:0];
    end else begin
      next_period = (diff[WIDTH] || (diff[WIDTH-1:0] < limit)) ? limit : diff[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/tr_move_sequencer.sv
// TR move sequencer: latches a move, settles direction, ramps the step period
// (accel/cruise/decel) while counting step ticks, and ends on count, stop or abort.
module tr_move_sequencer
  import tr_pkg::*;
#(
  parameter int unsigned WIDTH_TR   = WIDTH_TR_DEF,
  parameter int unsigned WIDTH_CNT  = WIDTH_CNT_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic     clk,
  input  logic     rst,
  tr_move_if.slave bus
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  tr_state_t            state_q;
  logic                 drv_en_q;
  logic                 dir_q;
  logic [WIDTH_TR-1:0]  period_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 aborted_q;
  logic [WIDTH_CNT-1:0] pulse_cnt_q;

  logic [WIDTH_CNT-1:0] pnum_q;
  logic [WIDTH_TR-1:0]  pstart_q;
  logic [WIDTH_TR-1:0]  ptarget_q;
  logic [WIDTH_TR-1:0]  pstep_q;
  logic [WIDTH_CNT-1:0] accel_q;
  logic [15:0]          settle_q;
  logic                 stopping_q;

  logic [WIDTH_CNT-1:0] pulse_cnt_d;
  logic [WIDTH_CNT-1:0] rem;
  logic                 rem_zero;
  logic                 decel_due;
  logic [WIDTH_TR-1:0]  period_dn;
  logic [WIDTH_TR-1:0]  period_up;
  logic [WIDTH_TR-1:0]  target_sane;

  // Speed-up candidate: one step faster, never below the cruise period
  tr_ramp_step #(.WIDTH(WIDTH_TR)) u_ramp_dn (
    .period      (period_q),
    .step        (pstep_q),
    .limit       (ptarget_q),
    .dir_up      (1'b0),
    .next_period (period_dn)
  );

  // Slow-down candidate: one step slower, never above the start period
  tr_ramp_step #(.WIDTH(WIDTH_TR)) u_ramp_up (
    .period      (period_q),
    .step        (pstep_q),
    .limit       (pstart_q),
    .dir_up      (1'b1),
    .next_period (period_up)
  );

  // Tick bookkeeping and command sanitising
  always_comb begin
    pulse_cnt_d = (&pulse_cnt_q) ? pulse_cnt_q : pulse_cnt_q + WIDTH_CNT'(1);
    rem         = pnum_q - pulse_cnt_d;
    rem_zero    = (rem == '0);
    // Old accel count: the tick that triggers decel takes the first slow-down
    // step instead of another speed-up step, so the ramp stays symmetric.
    decel_due   = (rem <= accel_q);
    target_sane = ((bus.period_step == '0) || (bus.period_target > bus.period_start))
                  ? bus.period_start : bus.period_target;
  end

  // Move FSM with registered outputs and command latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      drv_en_q    <= 1'b0;
      dir_q       <= 1'b0;
      period_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      pulse_cnt_q <= '0;
      pnum_q      <= '0;
      pstart_q    <= '0;
      ptarget_q   <= '0;
      pstep_q     <= '0;
      accel_q     <= '0;
      settle_q    <= '0;
      stopping_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.start && !bus.abort) begin
          pnum_q      <= bus.pulse_num;
          pstart_q    <= bus.period_start;
          ptarget_q   <= target_sane;
          pstep_q     <= bus.period_step;
          pulse_cnt_q <= '0;
          aborted_q   <= 1'b0;
          dir_q       <= bus.dir_cmd;
          accel_q     <= '0;
          stopping_q  <= 1'b0;
          settle_q    <= '0;
          if (bus.pulse_num == '0) begin
            done_q <= 1'b1;
          end else begin
            state_q  <= SETTLE;
            busy_q   <= 1'b1;
            period_q <= bus.period_start;
          end
        end
      end else if (bus.abort) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        drv_en_q  <= 1'b0;
        done_q    <= 1'b1;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          SETTLE: begin
            if (bus.stop) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (settle_q == SETTLE_LAST) begin
              drv_en_q <= 1'b1;
              accel_q  <= '0;
              state_q  <= (ptarget_q == pstart_q) ? CRUISE : ACCEL;
            end else begin
              settle_q <= settle_q + 16'd1;
            end
          end
          ACCEL, CRUISE: begin
            if (bus.step_tick) begin
              pulse_cnt_q <= pulse_cnt_d;
              if (rem_zero) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                drv_en_q <= 1'b0;
                done_q   <= 1'b1;
              end else if (bus.stop) begin
                state_q    <= DECEL;
                stopping_q <= 1'b1;
              end else if (decel_due) begin
                state_q  <= DECEL;
                period_q <= period_up;
              end else if (state_q == ACCEL) begin
                period_q <= period_dn;
                accel_q  <= accel_q + WIDTH_CNT'(1);
                if (period_dn == ptarget_q) begin
                  state_q <= CRUISE;
                end
              end
            end else if (bus.stop) begin
              state_q    <= DECEL;
              stopping_q <= 1'b1;
            end
          end
          DECEL: begin
            if (bus.step_tick) begin
              pulse_cnt_q <= pulse_cnt_d;
              if (rem_zero || (stopping_q && (period_up == pstart_q))) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                drv_en_q <= 1'b0;
                done_q   <= 1'b1;
              end
              if (!rem_zero) begin
                period_q <= period_up;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.drv_en    = drv_en_q;
  assign bus.dir       = dir_q;
  assign bus.period    = period_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_tr_move_sequencer.sv
// Directed bench for tr_move_sequencer with hand-computed expectations.
module tb_tr_move_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  tr_move_if #(.WIDTH_TR(16), .WIDTH_CNT(32)) bus ();

  tr_move_sequencer #(
    .WIDTH_TR   (16),
    .WIDTH_CNT  (32),
    .SETTLE_CYC (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_move(input logic d, input logic [31:0] n, input logic [15:0] ps,
                            input logic [15:0] pt, input logic [15:0] st);
    bus.dir_cmd       = d;
    bus.pulse_num     = n;
    bus.period_start  = ps;
    bus.period_target = pt;
    bus.period_step   = st;
    bus.start         = 1'b1;
    cyc(1);
    bus.start         = 1'b0;
  endtask

  task automatic tick();
    bus.step_tick = 1'b1;
    cyc(1);
    bus.step_tick = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".drv_en"}, 64'(bus.drv_en), 64'd0);
    check({tag, ".busy"},   64'(bus.busy),   64'd0);
    check({tag, ".done"},   64'(bus.done),   64'd0);
  endtask

  initial begin
    int p2[10];
    int p4[9];
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.abort = 1'b0; bus.dir_cmd = 1'b0;
    bus.pulse_num = '0; bus.period_start = '0; bus.period_target = '0;
    bus.period_step = '0; bus.step_tick = 1'b0;
    cyc(2);

    // Reset values
    check_idle_outputs("rst");
    check("rst.dir",       64'(bus.dir),       64'd0);
    check("rst.period",    64'(bus.period),    64'd0);
    check("rst.aborted",   64'(bus.aborted),   64'd0);
    check("rst.pulse_cnt", 64'(bus.pulse_cnt), 64'd0);
    rst = 1'b0;
    cyc(1);

    // 1: async reset in the middle of ACCEL
    start_move(1'b1, 32'd10, 16'd100, 16'd60, 16'd10);
    cyc(4);
    tick();
    check("t1.period_pre", 64'(bus.period), 64'd90);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("t1.async");
    check("t1.period", 64'(bus.period),    64'd0);
    check("t1.dir",    64'(bus.dir),       64'd0);
    check("t1.cnt",    64'(bus.pulse_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check_idle_outputs("t1.post");
    end

    // 2: full trapezoid, 10 steps
    start_move(1'b1, 32'd10, 16'd100, 16'd60, 16'd10);
    check("t2.busy",   64'(bus.busy),   64'd1);
    check("t2.dir",    64'(bus.dir),    64'd1);
    check("t2.period", 64'(bus.period), 64'd100);
    cyc(3);
    check("t2.drv_settle", 64'(bus.drv_en), 64'd0);
    cyc(1);
    check("t2.drv_on", 64'(bus.drv_en), 64'd1);
    p2 = '{90, 80, 70, 60, 60, 70, 80, 90, 100, 100};
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t2.period%0d", i + 1), 64'(bus.period),    64'(p2[i]));
      check($sformatf("t2.cnt%0d", i + 1),    64'(bus.pulse_cnt), 64'(i + 1));
      check($sformatf("t2.done%0d", i + 1),   64'(bus.done),      64'(i == 9));
    end
    check("t2.drv_off", 64'(bus.drv_en), 64'd0);
    check("t2.busy_off", 64'(bus.busy), 64'd0);
    cyc(1);
    check("t2.done_pulse", 64'(bus.done), 64'd0);

    // 3: triangular short move
    start_move(1'b0, 32'd3, 16'd100, 16'd60, 16'd10);
    cyc(4);
    tick();
    check("t3.period1", 64'(bus.period), 64'd90);
    tick();
    check("t3.period2", 64'(bus.period), 64'd100);
    check("t3.done2",   64'(bus.done),   64'd0);
    tick();
    check("t3.period3", 64'(bus.period),    64'd100);
    check("t3.done3",   64'(bus.done),      64'd1);
    check("t3.cnt",     64'(bus.pulse_cnt), 64'd3);
    cyc(1);
    check("t3.cnt_hold", 64'(bus.pulse_cnt), 64'd3);

    // 4: stop during cruise
    start_move(1'b1, 32'd100, 16'd100, 16'd60, 16'd10);
    cyc(4);
    for (int i = 0; i < 5; i++) tick();
    check("t4.cruise", 64'(bus.period), 64'd60);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    check("t4.stop_period", 64'(bus.period), 64'd60);
    check("t4.stop_busy",   64'(bus.busy),   64'd1);
    p4 = '{0, 0, 0, 0, 0, 70, 80, 90, 100};
    for (int i = 5; i < 9; i++) begin
      tick();
      check($sformatf("t4.period%0d", i + 1), 64'(bus.period), 64'(p4[i]));
      check($sformatf("t4.done%0d", i + 1),   64'(bus.done),   64'(i == 8));
    end
    check("t4.cnt",     64'(bus.pulse_cnt), 64'd9);
    check("t4.aborted", 64'(bus.aborted),   64'd0);
    check("t4.drv_off", 64'(bus.drv_en),    64'd0);

    // 5: abort during cruise
    start_move(1'b0, 32'd100, 16'd100, 16'd60, 16'd10);
    cyc(4);
    for (int i = 0; i < 7; i++) tick();
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    check("t5.drv_en",  64'(bus.drv_en),    64'd0);
    check("t5.done",    64'(bus.done),      64'd1);
    check("t5.aborted", 64'(bus.aborted),   64'd1);
    check("t5.cnt",     64'(bus.pulse_cnt), 64'd7);
    check("t5.busy",    64'(bus.busy),      64'd0);
    cyc(1);
    check("t5.aborted_hold", 64'(bus.aborted), 64'd1);

    // 6a: start+abort in IDLE is ignored
    bus.abort = 1'b1;
    start_move(1'b1, 32'd5, 16'd100, 16'd60, 16'd10);
    bus.abort = 1'b0;
    check("t6a.busy",    64'(bus.busy),    64'd0);
    check("t6a.aborted", 64'(bus.aborted), 64'd1);

    // 6b: zero-length move, also clears aborted
    start_move(1'b1, 32'd0, 16'd100, 16'd60, 16'd10);
    check("t6b.done",    64'(bus.done),    64'd1);
    check("t6b.busy",    64'(bus.busy),    64'd0);
    check("t6b.aborted", 64'(bus.aborted), 64'd0);
    check("t6b.cnt",     64'(bus.pulse_cnt), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check_idle_outputs("t6b.quiet");
    end

    // 6c: target above start -> constant period; start while busy ignored
    start_move(1'b1, 32'd3, 16'd100, 16'd200, 16'd10);
    cyc(4);
    check("t6c.drv_on", 64'(bus.drv_en), 64'd1);
    tick();
    check("t6c.period1", 64'(bus.period), 64'd100);
    start_move(1'b0, 32'd0, 16'd50, 16'd20, 16'd5);
    check("t6c.busy_ign", 64'(bus.busy),      64'd1);
    check("t6c.dir_ign",  64'(bus.dir),       64'd1);
    check("t6c.done_ign", 64'(bus.done),      64'd0);
    check("t6c.cnt_ign",  64'(bus.pulse_cnt), 64'd1);
    tick();
    check("t6c.period2", 64'(bus.period), 64'd100);
    tick();
    check("t6c.done", 64'(bus.done),      64'd1);
    check("t6c.cnt",  64'(bus.pulse_cnt), 64'd3);

    // 6d: tick and stop in the same cycle during ACCEL
    start_move(1'b1, 32'd100, 16'd100, 16'd60, 16'd10);
    cyc(4);
    tick();
    tick();
    check("t6d.period2", 64'(bus.period), 64'd80);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("t6d.cnt3",    64'(bus.pulse_cnt), 64'd3);
    check("t6d.period3", 64'(bus.period),    64'd80);
    check("t6d.busy3",   64'(bus.busy),      64'd1);
    tick();
    check("t6d.period4", 64'(bus.period), 64'd90);
    check("t6d.done4",   64'(bus.done),   64'd0);
    tick();
    check("t6d.period5", 64'(bus.period),    64'd100);
    check("t6d.done5",   64'(bus.done),      64'd1);
    check("t6d.cnt5",    64'(bus.pulse_cnt), 64'd5);

    // 6e: stop during SETTLE ends the move without steps
    start_move(1'b0, 32'd20, 16'd100, 16'd60, 16'd10);
    cyc(1);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    check("t6e.done",   64'(bus.done),      64'd1);
    check("t6e.busy",   64'(bus.busy),      64'd0);
    check("t6e.drv_en", 64'(bus.drv_en),    64'd0);
    check("t6e.cnt",    64'(bus.pulse_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
